// File: rtl/ssram_arb_pkg.sv
// Shared constants for the two-port SSRAM arbiter: data/lane geometry,
// read-owner bit positions and the all-lanes enable pattern.
package ssram_arb_pkg;

  localparam int SSRAM_DW    = 32;
  localparam int SSRAM_LANES = 4;

  localparam int OWN_P0 = 0;
  localparam int OWN_P1 = 1;

  localparam logic [SSRAM_LANES-1:0] ENB_ALL = 4'hF;

endpackage

// File: rtl/ssram_arb_starve_ctr.sv
// Saturating count of consecutive cycles a requester has been denied;
// sat_o tells the arbiter to let that requester override the priority port.
module ssram_arb_starve_ctr #(
  parameter int MAX_WAIT = 4,
  parameter int CW       = $clog2(MAX_WAIT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_i,
  input  logic          gnt_i,
  output logic [CW-1:0] cnt_o,
  output logic          sat_o
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!req_i || gnt_i) begin
      cnt_d = '0;
    end else if (cnt_q != MAX_CNT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = (cnt_q == MAX_CNT);

endmodule

// File: rtl/ssram_arbiter.sv
// Shares one byte-laned synchronous SRAM between a fixed-priority port 0 and a
// starvation-protected port 1; read data returns one cycle later, tagged per port.
module ssram_arbiter
  import ssram_arb_pkg::*;
#(
  parameter int AW       = 12,
  parameter int MAX_WAIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   p0_req,
  input  logic [AW-1:0]          p0_addr,
  input  logic [SSRAM_LANES-1:0] p0_wb,
  input  logic [SSRAM_DW-1:0]    p0_wdata,
  input  logic                   p1_req,
  input  logic [AW-1:0]          p1_addr,
  input  logic [SSRAM_LANES-1:0] p1_wb,
  input  logic [SSRAM_DW-1:0]    p1_wdata,
  output logic                   p0_gnt,
  output logic                   p1_gnt,
  output logic                   p0_rvalid,
  output logic                   p1_rvalid,
  output logic [SSRAM_DW-1:0]    rdata,
  output logic [AW-1:0]          sram_addr,
  output logic [SSRAM_LANES-1:0] sram_enb,
  output logic [SSRAM_LANES-1:0] sram_wb,
  output logic [SSRAM_DW-1:0]    sram_din,
  input  logic [SSRAM_DW-1:0]    sram_dout
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] wait_cnt;
  logic          wait_sat;
  logic          p0_win, p1_win;
  logic [1:0]    rd_owner_q, rd_owner_d;

  ssram_arb_starve_ctr #(
    .MAX_WAIT(MAX_WAIT),
    .CW      (CW)
  ) u_starve (
    .clk  (clk),
    .rst  (rst),
    .req_i(p1_req),
    .gnt_i(p1_win),
    .cnt_o(wait_cnt),
    .sat_o(wait_sat)
  );

  // Port 1 only beats a live port 0 request once it has waited MAX_WAIT cycles.
  assign p1_win = p1_req && (!p0_req || wait_sat);
  assign p0_win = p0_req && !p1_win;
  assign p0_gnt = p0_win;
  assign p1_gnt = p1_win;

  always_comb begin
    sram_addr = p0_addr;
    sram_din  = p0_wdata;
    sram_wb   = '0;
    sram_enb  = '0;
    if (p1_win) begin
      sram_addr = p1_addr;
      sram_din  = p1_wdata;
      sram_wb   = p1_wb;
      sram_enb  = (p1_wb != '0) ? p1_wb : ENB_ALL;
    end else if (p0_win) begin
      sram_wb  = p0_wb;
      sram_enb = (p0_wb != '0) ? p0_wb : ENB_ALL;
    end
  end

  always_comb begin
    rd_owner_d         = '0;
    rd_owner_d[OWN_P0] = p0_win && (p0_wb == '0);
    rd_owner_d[OWN_P1] = p1_win && (p1_wb == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_owner_q <= '0;
    end else begin
      rd_owner_q <= rd_owner_d;
    end
  end

  assign p0_rvalid = rd_owner_q[OWN_P0];
  assign p1_rvalid = rd_owner_q[OWN_P1];
  assign rdata     = sram_dout;

endmodule

// File: tb/tb_ssram_arbiter.sv
// Directed bench for ssram_arbiter: table of single-cycle vectors against a
// write-first byte-laned RAM model, plus hand sequences for starvation and reset.
module tb_ssram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p1_req;
  logic [11:0] p0_addr, p1_addr;
  logic [3:0]  p0_wb, p1_wb;
  logic [31:0] p0_wdata, p1_wdata;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [31:0] rdata;
  logic [11:0] sram_addr;
  logic [3:0]  sram_enb, sram_wb;
  logic [31:0] sram_din;
  logic [31:0] sram_dout = '0;

  logic [31:0] ramMem [0:4095];

  int nCompared = 0;
  int nFailed   = 0;

  typedef struct {
    logic        p0Req;
    logic [11:0] p0Addr;
    logic [3:0]  p0Wb;
    logic [31:0] p0Wdata;
    logic        p1Req;
    logic [11:0] p1Addr;
    logic [3:0]  p1Wb;
    logic [31:0] p1Wdata;
    logic [1:0]  expGnt;
    logic [3:0]  expEnb;
    logic [1:0]  expRvalid;
    logic [31:0] expRdata;
  } vec_t;

  vec_t vecs [0:14];

  always #5 clk = ~clk;

  ssram_arbiter #(.AW(12), .MAX_WAIT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .p0_req   (p0_req),
    .p0_addr  (p0_addr),
    .p0_wb    (p0_wb),
    .p0_wdata (p0_wdata),
    .p1_req   (p1_req),
    .p1_addr  (p1_addr),
    .p1_wb    (p1_wb),
    .p1_wdata (p1_wdata),
    .p0_gnt   (p0_gnt),
    .p1_gnt   (p1_gnt),
    .p0_rvalid(p0_rvalid),
    .p1_rvalid(p1_rvalid),
    .rdata    (rdata),
    .sram_addr(sram_addr),
    .sram_enb (sram_enb),
    .sram_wb  (sram_wb),
    .sram_din (sram_din),
    .sram_dout(sram_dout)
  );

  // Four write-first byte banks: an enabled written lane also returns the new byte.
  always @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (sram_enb[l]) begin
        if (sram_wb[l]) begin
          ramMem[sram_addr][8*l +: 8] <= sram_din[8*l +: 8];
          sram_dout[8*l +: 8]         <= sram_din[8*l +: 8];
        end else begin
          sram_dout[8*l +: 8] <= ramMem[sram_addr][8*l +: 8];
        end
      end
    end
  end

  function automatic vec_t mk(input logic r0, input logic [11:0] a0, input logic [3:0] w0,
                              input logic [31:0] d0, input logic r1, input logic [11:0] a1,
                              input logic [3:0] w1, input logic [31:0] d1, input logic [1:0] g,
                              input logic [3:0] e, input logic [1:0] rv, input logic [31:0] rd);
    vec_t v;
    v.p0Req = r0; v.p0Addr = a0; v.p0Wb = w0; v.p0Wdata = d0;
    v.p1Req = r1; v.p1Addr = a1; v.p1Wb = w1; v.p1Wdata = d1;
    v.expGnt = g; v.expEnb = e; v.expRvalid = rv; v.expRdata = rd;
    return v;
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nFailed++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    p0_req = v.p0Req; p0_addr = v.p0Addr; p0_wb = v.p0Wb; p0_wdata = v.p0Wdata;
    p1_req = v.p1Req; p1_addr = v.p1Addr; p1_wb = v.p1Wb; p1_wdata = v.p1Wdata;
  endtask

  // Called at the falling edge: grant/SRAM pins belong to this cycle, rvalid to the last.
  task automatic checkOutput(input string tag, input vec_t v);
    logic [3:0]  expWb;
    expWb = v.expGnt[1] ? v.p1Wb : (v.expGnt[0] ? v.p0Wb : 4'h0);
    compare({tag, ".gnt"}, {30'd0, p1_gnt, p0_gnt}, {30'd0, v.expGnt});
    compare({tag, ".enb"}, {28'd0, sram_enb}, {28'd0, v.expEnb});
    compare({tag, ".wb"}, {28'd0, sram_wb}, {28'd0, expWb});
    compare({tag, ".rvalid"}, {30'd0, p1_rvalid, p0_rvalid}, {30'd0, v.expRvalid});
    if (v.expGnt[1]) compare({tag, ".addr"}, {20'd0, sram_addr}, {20'd0, v.p1Addr});
    else if (v.expGnt[0]) compare({tag, ".addr"}, {20'd0, sram_addr}, {20'd0, v.p0Addr});
    if (v.expRvalid != 2'b00) compare({tag, ".rdata"}, rdata, v.expRdata);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    logic [1:0] prevGnt;
    logic [1:0] expG;

    vecs[0]  = mk(1, 12'h010, 4'hF, 32'hCAFEBABE, 0, 12'h000, 4'h0, 32'h0, 2'b01, 4'hF, 2'b00, 32'h0);
    vecs[1]  = mk(1, 12'h010, 4'h0, 32'h0,        0, 12'h000, 4'h0, 32'h0, 2'b01, 4'hF, 2'b00, 32'h0);
    vecs[2]  = mk(1, 12'h010, 4'h1, 32'h00000055, 0, 12'h000, 4'h0, 32'h0, 2'b01, 4'h1, 2'b01, 32'hCAFEBABE);
    vecs[3]  = mk(1, 12'h010, 4'h0, 32'h0,        0, 12'h000, 4'h0, 32'h0, 2'b01, 4'hF, 2'b00, 32'h0);
    vecs[4]  = mk(0, 12'h000, 4'h0, 32'h0,        0, 12'h000, 4'h0, 32'h0, 2'b00, 4'h0, 2'b01, 32'hCAFEBA55);
    vecs[5]  = mk(0, 12'h000, 4'h0, 32'h0,        1, 12'h014, 4'hF, 32'h12345678, 2'b10, 4'hF, 2'b00, 32'h0);
    vecs[6]  = mk(0, 12'h000, 4'h0, 32'h0,        1, 12'h014, 4'h0, 32'h0, 2'b10, 4'hF, 2'b00, 32'h0);
    vecs[7]  = mk(0, 12'h000, 4'h0, 32'h0,        0, 12'h000, 4'h0, 32'h0, 2'b00, 4'h0, 2'b10, 32'h12345678);
    vecs[8]  = mk(1, 12'h010, 4'h0, 32'h0,        0, 12'h000, 4'h0, 32'h0, 2'b01, 4'hF, 2'b00, 32'h0);
    vecs[9]  = mk(0, 12'h000, 4'h0, 32'h0,        1, 12'h014, 4'h0, 32'h0, 2'b10, 4'hF, 2'b01, 32'hCAFEBA55);
    vecs[10] = mk(0, 12'h000, 4'h0, 32'h0,        0, 12'h000, 4'h0, 32'h0, 2'b00, 4'h0, 2'b10, 32'h12345678);
    vecs[11] = mk(1, 12'h020, 4'hF, 32'hA5A5A5A5, 0, 12'h000, 4'h0, 32'h0, 2'b01, 4'hF, 2'b00, 32'h0);
    vecs[12] = mk(0, 12'h000, 4'h0, 32'h0,        1, 12'h020, 4'h0, 32'h0, 2'b10, 4'hF, 2'b00, 32'h0);
    vecs[13] = mk(1, 12'h030, 4'hF, 32'h0BADF00D, 0, 12'h000, 4'h0, 32'h0, 2'b01, 4'hF, 2'b10, 32'hA5A5A5A5);
    vecs[14] = mk(0, 12'h000, 4'h0, 32'h0,        0, 12'h000, 4'h0, 32'h0, 2'b00, 4'h0, 2'b00, 32'h0);

    rst = 1'b1;
    applyStimulus(vecs[14]);
    @(negedge clk);
    compare("reset.gnt", {30'd0, p1_gnt, p0_gnt}, 32'd0);
    compare("reset.enb", {28'd0, sram_enb}, 32'd0);
    compare("reset.rvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
    compare("reset.waitcnt", 32'(dut.wait_cnt), 32'd0);
    nextCycle();
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i), vecs[i]);
      nextCycle();
    end

    // Both ports reading continuously: P0 x4 then one P1 override, twice.
    v = mk(1, 12'h010, 4'h0, 32'h0, 1, 12'h014, 4'h0, 32'h0, 2'b00, 4'hF, 2'b00, 32'h0);
    applyStimulus(v);
    prevGnt = 2'b00;
    for (int i = 0; i < 10; i++) begin
      expG = ((i % 5) == 4) ? 2'b10 : 2'b01;
      @(negedge clk);
      compare($sformatf("starve%0d.gnt", i), {30'd0, p1_gnt, p0_gnt}, {30'd0, expG});
      compare($sformatf("starve%0d.waitcnt", i), 32'(dut.wait_cnt), 32'(i % 5));
      compare($sformatf("starve%0d.rvalid", i), {30'd0, p1_rvalid, p0_rvalid}, {30'd0, prevGnt});
      if (prevGnt != 2'b00)
        compare($sformatf("starve%0d.rdata", i), rdata, prevGnt[1] ? 32'h12345678 : 32'hCAFEBA55);
      prevGnt = expG;
      nextCycle();
    end

    // P1 gives up after two denied cycles; re-requesting starts the count over.
    @(negedge clk);
    compare("drop0.waitcnt", 32'(dut.wait_cnt), 32'd0);
    nextCycle();
    @(negedge clk);
    compare("drop1.waitcnt", 32'(dut.wait_cnt), 32'd1);
    nextCycle();
    p1_req = 1'b0;
    @(negedge clk);
    compare("drop2.gnt", {30'd0, p1_gnt, p0_gnt}, 32'd1);
    compare("drop2.waitcnt", 32'(dut.wait_cnt), 32'd2);
    nextCycle();
    p1_req = 1'b1;
    @(negedge clk);
    compare("drop3.waitcnt", 32'(dut.wait_cnt), 32'd0);
    nextCycle();
    @(negedge clk);
    compare("drop4.waitcnt", 32'(dut.wait_cnt), 32'd1);
    compare("drop4.gnt", {30'd0, p1_gnt, p0_gnt}, 32'd1);
    nextCycle();

    // P0 read granted, then reset pulsed across the edge that would return it.
    @(negedge clk);
    compare("rstmid.gnt", {30'd0, p1_gnt, p0_gnt}, 32'd1);
    compare("rstmid.prevrvalid", {31'd0, p0_rvalid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    compare("rstmid.asyncrvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
    compare("rstmid.asyncwaitcnt", 32'(dut.wait_cnt), 32'd0);
    applyStimulus(vecs[14]);
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    compare("rstpost.rvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
    compare("rstpost.waitcnt", 32'(dut.wait_cnt), 32'd0);
    nextCycle();
    applyStimulus(vecs[8]);
    @(negedge clk);
    checkOutput("rstnext.rd", vecs[8]);
    nextCycle();
    applyStimulus(vecs[4]);
    @(negedge clk);
    checkOutput("rstnext.ret", vecs[4]);
    nextCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
